ecdsa_verify_scheduler: RTL and testbench
=========================================

# ecdsa_verify_scheduler

Shares one ECDSA verifier engine between `NUM_REQ` requesters, such as the host bus port, the signature FIFO and the self-test unit. It grants requests round-robin and latches the winner's operands. It holds those operands stable for the whole verification, sequences the engine's start/done handshake and returns a tagged result. A watchdog aborts jobs when the engine hangs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, 200: maximum cycles in WAIT before abort. Must exceed the engine's nominal 93-cycle latency.
- `ID_W`, `$clog2(NUM_REQ)`: requester tag width (derived).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset is synchronous and active-low.
- `req_valid` in `NUM_REQ`: per-requester job request.
- `req_ready` out `NUM_REQ`: one-hot grant; accepted when `req_valid[i] & req_ready[i]`.
- `req_msg_hash` in `NUM_REQ*256`: hash, slot i at `[i*256 +: 256]`.
- `req_signature` in `NUM_REQ*512`: `{r,s}` per slot.
- `req_pub_key_x` in `NUM_REQ*256`: public key X coordinate per slot.
- `req_pub_key_y` in `NUM_REQ*256`: public key Y coordinate per slot.
- `ver_start` out 1: one-cycle start pulse to the engine.
- `ver_msg_hash` out 256: latched operand.
- `ver_signature` out 512: latched operand.
- `ver_pub_key_x` out 256: latched operand.
- `ver_pub_key_y` out 256: latched operand.
- `ver_busy` in 1: engine busy.
- `ver_done` in 1: engine completion pulse.
- `ver_valid` in 1: engine signature result.
- `ver_error` in 1: engine error pulse.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out `ID_W`: index of the requester that owns the result.
- `rsp_sig_ok` out 1: signature valid.
- `rsp_error` out 1: engine error or timeout.
- `rsp_timeout` out 1: watchdog abort.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any `req_valid` is high and `ver_busy` is 0, assert `req_ready` for the round-robin winner; the search starts at `rr_ptr`.
  - On the handshake, latch the winner's operands and ID, set `rr_ptr` to winner+1 (mod `NUM_REQ`), and go to ISSUE.
- ISSUE: drive `ver_start` high for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT:
  - `ver_done` → capture `ver_valid` into `rsp_sig_ok`, `rsp_error`=0.
  - `ver_error` → `rsp_sig_ok`=0, `rsp_error`=1.
  - Either event moves the FSM to RESPOND.
  - If both arrive in the same cycle, `ver_error` wins.
- RESPOND: hold `rsp_valid` and all `rsp_*` outputs stable until `rsp_ready`, then go to IDLE.
- The `ver_*` operand outputs stay constant from ISSUE until the FSM leaves RESPOND. The engine samples hash and key late, so this is required.
- `ver_done` and `ver_error` are ignored outside WAIT. This drops stale completions after a timeout.
- `req_ready` is combinational from state, `ver_busy`, `req_valid` and `rr_ptr`. It is never high outside IDLE.
- A requester that drops `req_valid` before the handshake forfeits its turn. No grant is held for it.

## Timing
- Reset values (synchronous, `rst_n`=0 at a clock edge):
  - State is IDLE, `rr_ptr`=0, watchdog=0.
  - All outputs are 0: `req_ready`, `ver_start`, `ver_*` operands, `rsp_valid`, `rsp_id`, `rsp_sig_ok`, `rsp_error`, `rsp_timeout`.
- Cycle sequence:
  - Cycle 0: accept handshake.
  - Cycle 1: `ver_start`=1.
  - `rsp_valid` rises in the cycle after `ver_done`/`ver_error` is sampled high.
- Back-to-back: the next grant is possible in the cycle after the `rsp_valid & rsp_ready` handshake, provided `ver_busy`=0.
- Reset mid-operation: the job is abandoned and no response is issued. The engine shares the system reset.

## Configuration
- `ECDSA_SCHED_TIMEOUT_EN` defined (watchdog on):
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without done/error, go to RESPOND with `rsp_timeout`=1, `rsp_error`=1, `rsp_sig_ok`=0.
  - The next grant then waits for `ver_busy`=0.
- Not defined: no counter is built, WAIT lasts indefinitely, and `rsp_timeout` is tied to 0.

## Structure
- Package `ecdsa_pkg`:
  - Scheduler state encoding.
  - `SIG_W`=512 and `KEY_W`=256 constants.
  - The secp256k1 order `N`, used by the bench to build out-of-range signatures.
- Sub-module `rr_arbiter`:
  - Parameterised on `NUM_REQ`.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.

## Test plan
- Single request:
  - Stimulus: requester 2, valid secp256k1 vector.
  - Response: `ver_start` one cycle after the handshake; `rsp_id`=2, `rsp_sig_ok` follows `ver_valid`; `rsp_error`=0.
- Fairness:
  - Stimulus: all four `req_valid` high continuously, `rsp_ready`=1.
  - Response: grants in order 0,1,2,3,0. No requester is granted twice before another pending requester is served.
- Engine error:
  - Stimulus: signature with r=0.
  - Response: engine `ver_error` → `rsp_error`=1, `rsp_sig_ok`=0, `rsp_timeout`=0.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=16 and a stub engine that never responds.
  - Response: `rsp_valid` with `rsp_timeout`=1 exactly 17 cycles after `ver_start`. No new grant while the stub holds `ver_busy`=1. A late `ver_done` is ignored.
- Backpressure:
  - Stimulus: `rsp_ready` held low for 50 cycles.
  - Response: `rsp_*` stable throughout; `req_ready` stays 0; the next grant comes 1 cycle after release.
- Reset mid-WAIT:
  - Stimulus: assert `rst_n`=0 for one edge mid-WAIT.
  - Response: all outputs 0 at the next edge; state IDLE; no `rsp_valid` for the abandoned job.

Source files
------------

// File: rtl/ecdsa_verify_scheduler_pkg.sv
// Shared types and constants for the ECDSA verifier scheduler.
package ecdsa_pkg;

  localparam int HASH_W = 256;
  localparam int KEY_W  = 256;
  localparam int SIG_W  = 512;

  // secp256k1 group order; r or s outside [1, N-1] is a malformed signature.
  localparam logic [255:0] N =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ecdsa_verify_scheduler_if.sv
// Requester, engine and response signals of the verifier scheduler.
// master = scheduler side, slave = requesters / engine / consumer side.
interface ecdsa_verify_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  import ecdsa_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*HASH_W-1:0] req_msg_hash;
  logic [NUM_REQ*SIG_W-1:0]  req_signature;
  logic [NUM_REQ*KEY_W-1:0]  req_pub_key_x;
  logic [NUM_REQ*KEY_W-1:0]  req_pub_key_y;

  logic              ver_start;
  logic [HASH_W-1:0] ver_msg_hash;
  logic [SIG_W-1:0]  ver_signature;
  logic [KEY_W-1:0]  ver_pub_key_x;
  logic [KEY_W-1:0]  ver_pub_key_y;
  logic              ver_busy;
  logic              ver_done;
  logic              ver_valid;
  logic              ver_error;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic            rsp_sig_ok;
  logic            rsp_error;
  logic            rsp_timeout;

  modport master (
    input  req_valid, req_msg_hash, req_signature, req_pub_key_x, req_pub_key_y,
    input  ver_busy, ver_done, ver_valid, ver_error, rsp_ready,
    output req_ready, ver_start, ver_msg_hash, ver_signature, ver_pub_key_x, ver_pub_key_y,
    output rsp_valid, rsp_id, rsp_sig_ok, rsp_error, rsp_timeout
  );

  modport slave (
    output req_valid, req_msg_hash, req_signature, req_pub_key_x, req_pub_key_y,
    output ver_busy, ver_done, ver_valid, ver_error, rsp_ready,
    input  req_ready, ver_start, ver_msg_hash, ver_signature, ver_pub_key_x, ver_pub_key_y,
    input  rsp_valid, rsp_id, rsp_sig_ok, rsp_error, rsp_timeout
  );

endinterface

// File: rtl/ecdsa_verify_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  function automatic logic [ID_W-1:0] wrap(input int v);
    return ID_W'(v % NUM_REQ);
  endfunction

  // Scan farthest-first so the requester nearest to ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req[wrap(int'(ptr) + k)]) begin
        gnt                       = '0;
        gnt[wrap(int'(ptr) + k)]  = 1'b1;
        idx                       = wrap(int'(ptr) + k);
      end
    end
  end

endmodule

// File: rtl/ecdsa_verify_scheduler.sv
// Shares one ECDSA verifier engine among NUM_REQ requesters (round-robin).
// Optional watchdog: define ECDSA_SCHED_TIMEOUT_EN to abort hung jobs.
module ecdsa_verify_scheduler
  import ecdsa_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input logic                      clk,
  input logic                      rst_n,
  ecdsa_verify_scheduler_if.master bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ecdsa_verify_scheduler: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  sched_state_e state, state_nxt;

  logic [ID_W-1:0]    rr_ptr, arb_idx, rsp_id_q;
  logic [NUM_REQ-1:0] arb_gnt, grant;
  logic               accept, rsp_evt, wd_hit;
  logic               rsp_ok_q, rsp_err_q;

  logic [HASH_W-1:0] sel_hash, hash_q;
  logic [SIG_W-1:0]  sel_sig, sig_q;
  logic [KEY_W-1:0]  sel_kx, kx_q, sel_ky, ky_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign grant   = (state == S_IDLE && !bus.ver_busy) ? arb_gnt : '0;
  assign accept  = |grant;
  assign rsp_evt = bus.ver_done | bus.ver_error;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT:    if (rsp_evt || wd_hit) state_nxt = S_RESPOND;
      S_RESPOND: if (bus.rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sel_hash = '0;
    sel_sig  = '0;
    sel_kx   = '0;
    sel_ky   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == ID_W'(i)) begin
        sel_hash = bus.req_msg_hash[i*HASH_W +: HASH_W];
        sel_sig  = bus.req_signature[i*SIG_W +: SIG_W];
        sel_kx   = bus.req_pub_key_x[i*KEY_W +: KEY_W];
        sel_ky   = bus.req_pub_key_y[i*KEY_W +: KEY_W];
      end
    end
  end

  // Operands are only written at a grant, so they stay put through RESPOND.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      hash_q    <= '0;
      sig_q     <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      rsp_id_q  <= '0;
      rsp_ok_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        hash_q   <= sel_hash;
        sig_q    <= sel_sig;
        kx_q     <= sel_kx;
        ky_q     <= sel_ky;
        rsp_id_q <= arb_idx;
        rr_ptr   <= (arb_idx == ID_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
      end
      if (state == S_WAIT) begin
        if (bus.ver_error) begin
          rsp_ok_q  <= 1'b0;
          rsp_err_q <= 1'b1;
        end else if (bus.ver_done) begin
          rsp_ok_q  <= bus.ver_valid;
          rsp_err_q <= 1'b0;
        end else if (wd_hit) begin
          rsp_ok_q  <= 1'b0;
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef ECDSA_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);

  logic [WD_W-1:0] wdog;
  logic            rsp_to_q;

  // Fires on the WAIT cycle in which the count would reach TIMEOUT_CYCLES.
  assign wd_hit = (state == S_WAIT) && (wdog == WD_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog     <= '0;
      rsp_to_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + 1'b1;
      if (state == S_WAIT) begin
        if (rsp_evt)     rsp_to_q <= 1'b0;
        else if (wd_hit) rsp_to_q <= 1'b1;
      end
    end
  end

  assign bus.rsp_timeout = rsp_to_q;
`else
  assign wd_hit          = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  assign bus.req_ready     = grant;
  assign bus.ver_start     = (state == S_ISSUE);
  assign bus.ver_msg_hash  = hash_q;
  assign bus.ver_signature = sig_q;
  assign bus.ver_pub_key_x = kx_q;
  assign bus.ver_pub_key_y = ky_q;
  assign bus.rsp_valid     = (state == S_RESPOND);
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_sig_ok    = rsp_ok_q;
  assign bus.rsp_error     = rsp_err_q;

endmodule

// File: tb/tb_ecdsa_verify_scheduler.sv
// Directed + randomized bench for ecdsa_verify_scheduler with a stub engine
// and a round-robin / result reference model.
module tb_ecdsa_verify_scheduler;
  import ecdsa_pkg::*;

  localparam int NR  = 4;
  localparam int TO  = 16;
  localparam int IDW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecdsa_verify_scheduler_if #(.NUM_REQ(NR)) bus ();

  ecdsa_verify_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Stub engine: mode 0 normal, 1 hang until released, 2 done+error together.
  int   eng_lat     = 5;
  int   eng_mode    = 0;
  logic eng_release = 1'b0;
  logic inj_done    = 1'b0;
  logic eng_busy, eng_done, eng_err, eng_ok;
  int   eng_cnt;

  function automatic bit bad_sig(input logic [511:0] sig);
    logic [255:0] r, s;
    r = sig[511:256];
    s = sig[255:0];
    return (r == 0) || (s == 0) || (r >= N) || (s >= N);
  endfunction

  function automatic bit sig_rule(input logic [255:0] h, input logic [255:0] x, input logic [255:0] y);
    return ^(h[15:0] ^ x[15:0] ^ y[15:0]);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_busy <= 1'b0; eng_done <= 1'b0; eng_err <= 1'b0; eng_ok <= 1'b0; eng_cnt <= 0;
    end else begin
      eng_done <= 1'b0;
      eng_err  <= 1'b0;
      if (bus.ver_start) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 1;
      end else if (eng_busy) begin
        if (eng_mode == 1) begin
          if (eng_release) eng_busy <= 1'b0;
        end else if (eng_cnt >= eng_lat) begin
          eng_busy <= 1'b0;
          if (bad_sig(bus.ver_signature)) eng_err <= 1'b1;
          else begin
            eng_done <= 1'b1;
            eng_ok   <= sig_rule(bus.ver_msg_hash, bus.ver_pub_key_x, bus.ver_pub_key_y);
          end
          if (eng_mode == 2) begin
            eng_done <= 1'b1;
            eng_err  <= 1'b1;
          end
        end else eng_cnt <= eng_cnt + 1;
      end
    end
  end

  assign bus.ver_busy  = eng_busy;
  assign bus.ver_done  = eng_done | inj_done;
  assign bus.ver_error = eng_err;
  assign bus.ver_valid = eng_ok;

  // Reference model state: per-slot operands and the round-robin pointer.
  logic [255:0] m_hash [NR];
  logic [511:0] m_sig  [NR];
  logic [255:0] m_kx   [NR];
  logic [255:0] m_ky   [NR];
  int           m_ptr = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pick(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++)
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] g;
    g = '0;
    if (i >= 0) g[i] = 1'b1;
    return g;
  endfunction

  function automatic logic [3:0] ops_match(input int w);
    return {bus.ver_msg_hash === m_hash[w], bus.ver_signature === m_sig[w],
            bus.ver_pub_key_x === m_kx[w], bus.ver_pub_key_y === m_ky[w]};
  endfunction

  task automatic rnd_ops(input int i);
    for (int w = 0; w < 8; w++) begin
      m_hash[i][w*32 +: 32] = $urandom();
      m_kx[i][w*32 +: 32]   = $urandom();
      m_ky[i][w*32 +: 32]   = $urandom();
    end
    for (int w = 0; w < 16; w++) m_sig[i][w*32 +: 32] = $urandom();
  endtask

  task automatic push_ops();
    for (int i = 0; i < NR; i++) begin
      bus.req_msg_hash[i*256 +: 256]  = m_hash[i];
      bus.req_signature[i*512 +: 512] = m_sig[i];
      bus.req_pub_key_x[i*256 +: 256] = m_kx[i];
      bus.req_pub_key_y[i*256 +: 256] = m_ky[i];
    end
  endtask

  // Starts just after a negedge with the FSM idle; ends likewise after the
  // response handshake.
  task automatic do_job(input int hold, input bit drop, output int win);
    bit hang, err_e, ok_e, prev, bad;
    logic [IDW+3:0] snap;
    int cyc;
    push_ops();
    #1;
    win = m_pick(bus.req_valid);
    chk("grant", bus.req_ready, oh(win));
    if (win < 0) return;
    @(negedge clk); #1;
    m_ptr = (win + 1) % NR;
    if (drop) bus.req_valid[win] = 1'b0;
    chk("ver_start", bus.ver_start, 1);
    chk("ops_latched", ops_match(win), 4'hF);
    hang  = (eng_mode == 1);
    err_e = hang || (eng_mode == 2) || bad_sig(m_sig[win]);
    ok_e  = !err_e && sig_rule(m_hash[win], m_kx[win], m_ky[win]);
    prev = 0; cyc = 0; bad = 0;
    while (!bus.rsp_valid && cyc < 400) begin
      prev = bus.ver_done | bus.ver_error;
      @(negedge clk); #1;
      cyc++;
      if (bus.req_ready != 0 || bus.ver_start || ops_match(win) != 4'hF) bad = 1;
    end
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("wait_quiet", bad, 0);
    if (hang) chk("to_latency", cyc, TO + 1);
    else      chk("rsp_after_evt", prev, 1);
    chk("rsp_id", bus.rsp_id, win);
    chk("rsp_sig_ok", bus.rsp_sig_ok, ok_e);
    chk("rsp_error", bus.rsp_error, err_e);
    chk("rsp_timeout", bus.rsp_timeout, hang);
    snap = {bus.rsp_valid, bus.rsp_id, bus.rsp_sig_ok, bus.rsp_error, bus.rsp_timeout};
    bad = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk); #1;
      if (snap !== {bus.rsp_valid, bus.rsp_id, bus.rsp_sig_ok, bus.rsp_error, bus.rsp_timeout}
          || bus.req_ready != 0 || ops_match(win) != 4'hF) bad = 1;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  win;
    bit  bad;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) rnd_ops(i);
    push_ops();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", {bus.req_ready, bus.ver_start, bus.rsp_valid, bus.rsp_id,
                    bus.rsp_sig_ok, bus.rsp_error, bus.rsp_timeout}, 0);
    chk("rst_ops", |{bus.ver_msg_hash, bus.ver_signature, bus.ver_pub_key_x, bus.ver_pub_key_y}, 0);
    rst_n = 1'b1;

    // Fairness: everyone asks continuously
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      rnd_ops(k % NR);
      do_job(0, 0, win);
      chk("fair_order", win, k % NR);
    end
    bus.req_valid = '0;

    // Single request from requester 2 with a well-formed vector
    m_hash[2] = 256'h4B688DF40BCEDBE641DDB16FF0A1842D9C67EA1C3BF63F3E0471BAA664531D1A;
    m_kx[2]   = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    m_ky[2]   = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
    m_sig[2]  = {256'h241097EFBF8B63BF145C8961DBDF10C310EFBB3B2676BBC0F8B08505C9E2F795,
                 256'h021006B7838609339E8B415A7F9ACB1B661828131AEF1ECBC7955DFB01F3CA0E};
    eng_lat = 7;
    bus.req_valid = 4'b0100;
    do_job(0, 1, win);
    chk("single_id", win, 2);

    // Engine error: r = 0
    rnd_ops(1);
    m_sig[1][511:256] = '0;
    bus.req_valid = 4'b0010;
    do_job(0, 1, win);

    // done and error in the same cycle
    eng_mode = 2;
    rnd_ops(3);
    bus.req_valid = 4'b1000;
    do_job(0, 1, win);
    eng_mode = 0;

    // Backpressure: 50 cycles with another requester waiting
    rnd_ops(0); rnd_ops(1);
    bus.req_valid = 4'b0011;
    do_job(50, 1, win);
    chk("bp_first", win, 0);
    do_job(0, 1, win);
    chk("bp_next", win, 1);

`ifdef ECDSA_SCHED_TIMEOUT_EN
    // Hung engine: watchdog abort, no grant while busy, late done ignored
    eng_mode = 1;
    rnd_ops(2);
    bus.req_valid = 4'b0100;
    do_job(0, 1, win);
    bus.req_valid = 4'b0001;
    #1;
    bad = (bus.req_ready != 0);
    inj_done = 1'b1;
    @(negedge clk); #1;
    inj_done = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (bus.req_ready != 0 || bus.rsp_valid || bus.ver_start) bad = 1;
    end
    chk("to_hold_off", bad, 0);
    eng_release = 1'b1;
    @(negedge clk); #1;
    eng_release = 1'b0;
    eng_mode = 0;
    do_job(0, 1, win);
    chk("to_after_release", win, 0);
`endif

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < NR; i++) rnd_ops(i);
      if ($urandom_range(0, 3) == 0) m_sig[$urandom_range(0, NR-1)][511:256] = '0;
      if ($urandom_range(0, 5) == 0) m_sig[$urandom_range(0, NR-1)][255:0] = N;
      eng_lat = $urandom_range(1, 12);
      bus.req_valid = NR'($urandom_range(1, (1 << NR) - 1));
      do_job($urandom_range(0, 3), 1'($urandom_range(0, 1)), win);
    end

    // Reset in the middle of WAIT
    eng_lat = 30;
    rnd_ops(1);
    push_ops();
    bus.req_valid = 4'b0010;
    #1;
    win = m_pick(bus.req_valid);
    chk("rw_grant", bus.req_ready, oh(win));
    @(negedge clk); #1;
    bus.req_valid = '0;
    chk("rw_start", bus.ver_start, 1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rw_out", {bus.req_ready, bus.ver_start, bus.rsp_valid, bus.rsp_id,
                   bus.rsp_sig_ok, bus.rsp_error, bus.rsp_timeout}, 0);
    chk("rw_ops", |{bus.ver_msg_hash, bus.ver_signature, bus.ver_pub_key_x, bus.ver_pub_key_y}, 0);
    rst_n = 1'b1;
    m_ptr = 0;
    eng_lat = 5;
    bad = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (bus.rsp_valid || bus.ver_start) bad = 1;
    end
    chk("rw_no_rsp", bad, 0);
    bus.req_valid = '1;
    do_job(0, 0, win);
    chk("rw_ptr_reset", win, 0);
    bus.req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
